// File: rtl/asteroids_pkg.sv
// Shared types and constants for the asteroids special-stage wave scheduler.
// Holds the wave FSM encoding, the slot-count ceiling and the Y-randomising LFSR step.
package asteroids_pkg;

  localparam int unsigned MAX_SLOTS = 8;

  // 16-bit Galois LFSR, taps 16,14,13,11
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    LAUNCH = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } wave_state_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    lfsr_step = {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/lowest_free_slot.sv
// Priority encoder returning the lowest-index free slot and a found flag.
// Purely combinational; no handshake.
module lowest_free_slot
  import asteroids_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned IDX_W     = 2
) (
  input  logic [NUM_SLOTS-1:0] slot_free_i,
  output logic [IDX_W-1:0]     slot_idx_o,
  output logic                 found_o
);

  // Scan from the top so the lowest free index is the last one written.
  always_comb begin
    slot_idx_o = '0;
    found_o    = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (slot_free_i[i]) begin
        slot_idx_o = IDX_W'(i);
        found_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/asteroids_wave_scheduler.sv
// Launches one wave of asteroids into free mover slots, tracks liveness and hits, flags completion.
// Spawn pulse and event updates land 1 cycle after the decision; a full slot set stalls the launch, not the frame source.
module asteroids_wave_scheduler
  import asteroids_pkg::*;
#(
  parameter int unsigned NUM_SLOTS         = 4,
  parameter int unsigned TOTAL_ASTEROIDS   = 12,
  parameter int unsigned SPAWN_PERIOD      = 45,
  parameter int unsigned SPAWN_X           = 600,
  parameter int unsigned SPAWN_Y_MIN       = 32,
  parameter int unsigned SPAWN_Y_SPAN_LOG2 = 8,
  parameter int unsigned PIXEL_WIDTH       = 11,
  parameter logic [15:0] LFSR_SEED         = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   startOfFrame,
  input  logic                   stage_start,
  input  logic [NUM_SLOTS-1:0]   slot_hit,
  input  logic [NUM_SLOTS-1:0]   slot_exit,
  output logic [NUM_SLOTS-1:0]   spawn,
  output logic [PIXEL_WIDTH-1:0] spawn_x,
  output logic [PIXEL_WIDTH-1:0] spawn_y,
  output logic [NUM_SLOTS-1:0]   slot_active,
  output logic [7:0]             hit_count,
  output logic                   stage_done
);

  localparam int unsigned IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int unsigned FC_W  = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;

  localparam logic [FC_W-1:0]        LAST_FRAME  = FC_W'(SPAWN_PERIOD - 1);
  localparam logic [7:0]             LAST_LAUNCH = 8'(TOTAL_ASTEROIDS - 1);
  localparam logic [PIXEL_WIDTH-1:0] Y_BASE      = PIXEL_WIDTH'(SPAWN_Y_MIN);

  if (NUM_SLOTS < 1 || NUM_SLOTS > MAX_SLOTS) begin : g_bad_slots
    $error("asteroids_wave_scheduler: NUM_SLOTS out of range");
  end

  wave_state_t            state_q, state_d;
  logic [FC_W-1:0]        frame_cnt_q, frame_cnt_d;
  logic [7:0]             launched_q, launched_d;
  logic [15:0]            lfsr_q, lfsr_d;
  logic [NUM_SLOTS-1:0]   slot_active_q, slot_active_d;
  logic [7:0]             hit_count_q, hit_count_d;
  logic [NUM_SLOTS-1:0]   spawn_q, spawn_d;
  logic [PIXEL_WIDTH-1:0] spawn_y_q, spawn_y_d;

  logic [IDX_W-1:0]     free_idx;
  logic                 free_found;
  logic [NUM_SLOTS-1:0] free_onehot;
  logic [NUM_SLOTS-1:0] live_hit;
  logic [NUM_SLOTS-1:0] live_evt;
  logic [3:0]           hit_pop;
  logic [8:0]           hit_sum;

  lowest_free_slot #(
    .NUM_SLOTS (NUM_SLOTS),
    .IDX_W     (IDX_W)
  ) u_free (
    .slot_free_i (~slot_active_q),
    .slot_idx_o  (free_idx),
    .found_o     (free_found)
  );

  assign free_onehot = NUM_SLOTS'(1) << free_idx;

  // Events only matter on slots that were already live; a hit wins over a same-cycle exit.
  assign live_hit = slot_hit & slot_active_q;
  assign live_evt = (slot_hit | slot_exit) & slot_active_q;

  always_comb begin
    hit_pop = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      hit_pop = hit_pop + 4'(live_hit[i]);
    end
  end

  assign hit_sum = {1'b0, hit_count_q} + 9'(hit_pop);

  always_comb begin
    state_d       = state_q;
    frame_cnt_d   = frame_cnt_q;
    launched_d    = launched_q;
    lfsr_d        = lfsr_q;
    slot_active_d = slot_active_q & ~live_evt;
    hit_count_d   = hit_sum[8] ? 8'hFF : hit_sum[7:0];
    spawn_d       = '0;
    spawn_y_d     = spawn_y_q;

    if (stage_start) begin
      state_d       = WAIT;
      frame_cnt_d   = '0;
      launched_d    = '0;
      slot_active_d = '0;
      hit_count_d   = '0;
    end else begin
      case (state_q)
        WAIT: begin
          if (startOfFrame) begin
            if (frame_cnt_q == LAST_FRAME) begin
              frame_cnt_d = '0;
              state_d     = LAUNCH;
            end else begin
              frame_cnt_d = frame_cnt_q + FC_W'(1);
            end
          end
        end
        LAUNCH: begin
          // Held here with the frame counter frozen until a slot frees up.
          if (free_found) begin
            spawn_d       = free_onehot;
            slot_active_d = slot_active_d | free_onehot;
            spawn_y_d     = Y_BASE + PIXEL_WIDTH'(lfsr_q[SPAWN_Y_SPAN_LOG2-1:0]);
            lfsr_d        = lfsr_step(lfsr_q);
            launched_d    = launched_q + 8'd1;
            state_d       = (launched_q == LAST_LAUNCH) ? DRAIN : WAIT;
          end
        end
        DRAIN: begin
          if (slot_active_q == '0) begin
            state_d = DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q       <= IDLE;
      frame_cnt_q   <= '0;
      launched_q    <= '0;
      lfsr_q        <= LFSR_SEED;
      slot_active_q <= '0;
      hit_count_q   <= '0;
      spawn_q       <= '0;
      spawn_y_q     <= Y_BASE;
    end else begin
      state_q       <= state_d;
      frame_cnt_q   <= frame_cnt_d;
      launched_q    <= launched_d;
      lfsr_q        <= lfsr_d;
      slot_active_q <= slot_active_d;
      hit_count_q   <= hit_count_d;
      spawn_q       <= spawn_d;
      spawn_y_q     <= spawn_y_d;
    end
  end

  assign spawn       = spawn_q;
  assign spawn_x     = PIXEL_WIDTH'(SPAWN_X);
  assign spawn_y     = spawn_y_q;
  assign slot_active = slot_active_q;
  assign hit_count   = hit_count_q;
  assign stage_done  = (state_q == DONE);

endmodule

// File: tb/tb_asteroids_wave_scheduler.sv
// Bench for asteroids_wave_scheduler: a 12-asteroid and a 2-asteroid instance share stimulus.
// Directed wave scenarios, then random frames/events/restarts against a wave-level reference model.
module tb_asteroids_wave_scheduler;

  localparam int NS     = 4;
  localparam int PERIOD = 45;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetN = 1'b0;
  logic          startOfFrame = 1'b0;
  logic          stage_start = 1'b0;
  logic [NS-1:0] slot_hit = '0;
  logic [NS-1:0] slot_exit = '0;

  logic [NS-1:0] spawn_a, spawn_b, act_a, act_b;
  logic [10:0]   x_a, x_b, y_a, y_b;
  logic [7:0]    hc_a, hc_b;
  logic          done_a, done_b;

  asteroids_wave_scheduler dut_a (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .stage_start(stage_start),
    .slot_hit(slot_hit), .slot_exit(slot_exit), .spawn(spawn_a), .spawn_x(x_a), .spawn_y(y_a),
    .slot_active(act_a), .hit_count(hc_a), .stage_done(done_a)
  );

  asteroids_wave_scheduler #(.TOTAL_ASTEROIDS(2)) dut_b (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .stage_start(stage_start),
    .slot_hit(slot_hit), .slot_exit(slot_exit), .spawn(spawn_b), .spawn_x(x_b), .spawn_y(y_b),
    .slot_active(act_b), .hit_count(hc_b), .stage_done(done_b)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model, one entry per instance: running/launch-pending/draining/done flags,
  // frames seen since the last launch, live-slot set, hits and the Y generator.
  bit        m_run[2], m_want[2], m_drain[2], m_done[2];
  int        m_frames[2], m_launched[2], m_hits[2], m_y[2];
  bit [3:0]  m_live[2], m_spawn[2];
  bit [15:0] m_lfsr[2];

  function automatic bit [15:0] next_rand(input bit [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic model_step(input int k);
    bit [3:0] act, hv, ev, nxt;
    int nh, slot, tot;
    tot = (k == 0) ? 12 : 2;
    act = m_live[k];
    hv  = slot_hit & act;
    ev  = (slot_hit | slot_exit) & act;
    nh  = $countones(hv);
    m_spawn[k] = '0;
    if (!resetN) begin
      m_run[k] = 0; m_want[k] = 0; m_drain[k] = 0; m_done[k] = 0;
      m_frames[k] = 0; m_launched[k] = 0; m_hits[k] = 0; m_live[k] = '0;
      m_lfsr[k] = 16'hACE1; m_y[k] = 32;
    end else if (stage_start) begin
      m_run[k] = 1; m_want[k] = 0; m_drain[k] = 0; m_done[k] = 0;
      m_frames[k] = 0; m_launched[k] = 0; m_hits[k] = 0; m_live[k] = '0;
    end else begin
      nxt = act & ~ev;
      m_hits[k] = (m_hits[k] + nh > 255) ? 255 : m_hits[k] + nh;
      if (m_want[k]) begin
        slot = -1;
        for (int i = NS - 1; i >= 0; i--) if (!act[i]) slot = i;
        if (slot >= 0) begin
          m_spawn[k] = 4'(1 << slot);
          nxt[slot] = 1'b1;
          m_y[k] = 32 + int'(m_lfsr[k][7:0]);
          m_lfsr[k] = next_rand(m_lfsr[k]);
          m_launched[k]++;
          m_want[k] = 0;
          if (m_launched[k] == tot) m_drain[k] = 1;
        end
      end else if (m_drain[k]) begin
        if (act == 0) begin
          m_drain[k] = 0;
          m_done[k] = 1;
        end
      end else if (m_run[k] && !m_done[k] && startOfFrame) begin
        m_frames[k]++;
        if (m_frames[k] == PERIOD) begin
          m_frames[k] = 0;
          m_want[k] = 1;
        end
      end
      m_live[k] = nxt;
    end
  endtask

  int spawn_log[$];
  int y_log[$];

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      logic [3:0] sp, ac;
      logic [10:0] sx, sy;
      logic [7:0] hc;
      logic dn;
      sp = (k == 0) ? spawn_a : spawn_b;
      ac = (k == 0) ? act_a : act_b;
      sx = (k == 0) ? x_a : x_b;
      sy = (k == 0) ? y_a : y_b;
      hc = (k == 0) ? hc_a : hc_b;
      dn = (k == 0) ? done_a : done_b;
      check_eq($sformatf("spawn%0d", k), 32'(sp), 32'(m_spawn[k]));
      check_eq($sformatf("slot_active%0d", k), 32'(ac), 32'(m_live[k]));
      check_eq($sformatf("hit_count%0d", k), 32'(hc), 32'(m_hits[k]));
      check_eq($sformatf("stage_done%0d", k), 32'(dn), 32'(m_done[k]));
      check_eq($sformatf("spawn_x%0d", k), 32'(sx), 32'd600);
      if (m_spawn[k] != 0) check_eq($sformatf("spawn_y%0d", k), 32'(sy), 32'(m_y[k]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    compare_all();
    if (spawn_a != 0) begin
      for (int i = 0; i < NS; i++) if (spawn_a[i]) spawn_log.push_back(i);
      y_log.push_back(int'(y_a));
    end
  endtask

  task automatic cycle(input bit sof, input bit st, input logic [3:0] hit, input logic [3:0] ex);
    startOfFrame = sof;
    stage_start  = st;
    slot_hit     = hit;
    slot_exit    = ex;
    tick();
  endtask

  // Frames every other cycle until the log holds n spawns or the budget runs out.
  task automatic run_until_spawns(input int n, input int budget, output int sofs, output int cyc);
    bit sof;
    sofs = 0;
    cyc  = 0;
    while (spawn_log.size() < n && cyc < budget) begin
      sof = (cyc % 2 == 0);
      cycle(sof, 1'b0, 4'b0, 4'b0);
      if (sof) sofs++;
      cyc++;
    end
    check_eq("spawn_wait", 32'(spawn_log.size()), 32'(n));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int sofs, cyc;

    resetN = 1'b0;
    repeat (3) cycle(1'b0, 1'b0, 4'b0, 4'b0);
    check_eq("rst_active", 32'(act_a), 32'd0);
    check_eq("rst_y", 32'(y_a), 32'd32);
    check_eq("rst_done", 32'(done_a), 32'd0);
    resetN = 1'b1;
    repeat (2) cycle(1'b0, 1'b0, 4'b0, 4'b0);

    // First launch: 45 frames after start, slot 0, Y from the seed.
    cycle(1'b0, 1'b1, 4'b0, 4'b0);
    run_until_spawns(1, 200, sofs, cyc);
    check_eq("first_frames", 32'(sofs), 32'(PERIOD));
    check_eq("first_slot", 32'(spawn_log[0]), 32'd0);
    check_eq("first_y", 32'(y_log[0]), 32'd257);
    check_eq("first_active", 32'(act_a), 32'b0001);

    run_until_spawns(4, 600, sofs, cyc);
    for (int i = 1; i < 4; i++) check_eq($sformatf("order%0d", i), 32'(spawn_log[i]), 32'(i));
    check_eq("all_live", 32'(act_a), 32'hF);

    // Fifth launch blocks with every slot live, then takes the exited slot 2.
    for (int i = 0; i < 100; i++) cycle(i % 2 == 0, 1'b0, 4'b0, 4'b0);
    check_eq("blocked_count", 32'(spawn_log.size()), 32'd4);
    cycle(1'b0, 1'b0, 4'b0, 4'b0100);
    run_until_spawns(5, 10, sofs, cyc);
    check_eq("refill_delay", 32'(cyc), 32'd1);
    check_eq("refill_slot", 32'(spawn_log[4]), 32'd2);
    check_eq("exit_no_count", 32'(hc_a), 32'd0);

    cycle(1'b0, 1'b0, 4'b1010, 4'b0010);
    check_eq("dual_hit_active", 32'(act_a), 32'b0101);
    check_eq("dual_hit_count", 32'(hc_a), 32'd2);
    cycle(1'b0, 1'b0, 4'b0010, 4'b0);
    check_eq("dead_hit_active", 32'(act_a), 32'b0101);
    check_eq("dead_hit_count", 32'(hc_a), 32'd2);

    // Short wave drains: done one cycle after its last slot clears, then holds.
    cycle(1'b0, 1'b0, 4'b0001, 4'b0);
    check_eq("b_cleared", 32'(act_b), 32'd0);
    check_eq("b_hits", 32'(hc_b), 32'd2);
    check_eq("b_not_done", 32'(done_b), 32'd0);
    cycle(1'b0, 1'b0, 4'b0, 4'b0);
    check_eq("b_done", 32'(done_b), 32'd1);
    repeat (20) cycle(1'b1, 1'b0, 4'b0, 4'b0);
    check_eq("b_done_hold", 32'(done_b), 32'd1);

    cycle(1'b0, 1'b1, 4'b0, 4'b0);
    check_eq("restart_done", 32'(done_b), 32'd0);
    check_eq("restart_hits", 32'(hc_a), 32'd0);
    spawn_log.delete();
    run_until_spawns(3, 600, sofs, cyc);
    check_eq("three_live", 32'(act_a), 32'b0111);
    cycle(1'b0, 1'b1, 4'b0, 4'b0);
    check_eq("midwave_active", 32'(act_a), 32'd0);
    spawn_log.delete();
    run_until_spawns(1, 200, sofs, cyc);
    check_eq("midwave_frames", 32'(sofs), 32'(PERIOD));
    check_eq("midwave_slot", 32'(spawn_log[0]), 32'd0);

    // Random frames, events, restarts and resets.
    for (int i = 0; i < 5000; i++) begin
      logic [3:0] h, e;
      h = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'b0;
      e = ($urandom_range(0, 19) == 0) ? 4'($urandom) : 4'b0;
      resetN = ($urandom_range(0, 2499) != 0);
      cycle($urandom_range(0, 2) == 0, $urandom_range(0, 499) == 0, h, e);
    end
    resetN = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
